// File: rtl/selector_sync.sv
// Clock-synchronous waveform selector: synchronizes the SPI command strobe,
// range-checks the command and commits it at a waveform period boundary.
module selector_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_WAVES   = 4,
    parameter int RESET_SEL   = 0,
    parameter int WAIT_WRAP   = 1,
    parameter int TIMEOUT     = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cmd_in,
    input  logic       cmd_strobe,
    input  logic       wrap_pulse,
    output logic [3:0] selector,
    output logic       pending,
    output logic       changed,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [3:0]  SEL_INIT  = 4'(RESET_SEL);
    localparam logic [4:0]  WAVES     = 5'(NUM_WAVES);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   cap_q;

    logic [3:0]  sel_q, sel_d;
    logic [3:0]  pend_sel_q, pend_sel_d;
    logic [15:0] cnt_q, cnt_d;
    logic        changed_q, changed_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic cmd_bad, cmd_same, cap_valid, cap_bad, timeout_hit;
    logic commit_new, commit_old, load;

    // Strobe synchronizer plus registered rising-edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            cap_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], cmd_strobe};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            cap_q       <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
        end
    end

    assign cmd_bad     = {1'b0, cmd_in} >= WAVES;
    assign cmd_same    = (cmd_in == sel_q) && (state_q == IDLE);
    assign cap_valid   = cap_q && !cmd_bad && !cmd_same;
    assign cap_bad     = cap_q && cmd_bad;
    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A fresh valid capture beats any pending value; with wrap it commits directly
    always_comb begin
        state_d    = state_q;
        commit_new = 1'b0;
        commit_old = 1'b0;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_valid) begin
                    if (wrap_pulse) begin
                        commit_new = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (cap_valid && wrap_pulse) begin
                    commit_new = 1'b1;
                    state_d    = IDLE;
                end else if (cap_valid) begin
                    load = 1'b1;
                end else if (wrap_pulse || timeout_hit || (WAIT_WRAP == 0)) begin
                    commit_old = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d      = sel_q;
        pend_sel_d = pend_sel_q;
        cnt_d      = '0;
        changed_d  = commit_new | commit_old;
        err_d      = cap_bad;
        err_cnt_d  = err_cnt_q;
        if (commit_new) begin
            sel_d = cmd_in;
        end else if (commit_old) begin
            sel_d = pend_sel_q;
        end
        if (load) begin
            pend_sel_d = cmd_in;
        end
        if ((state_q == PENDING) && !load) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (cap_bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q      <= SEL_INIT;
            pend_sel_q <= SEL_INIT;
            cnt_q      <= '0;
            changed_q  <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            sel_q      <= sel_d;
            pend_sel_q <= pend_sel_d;
            cnt_q      <= cnt_d;
            changed_q  <= changed_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign selector = sel_q;
    assign pending  = (state_q == PENDING);
    assign changed  = changed_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_selector_sync.sv
// Self-checking bench for selector_sync: directed sequences, a vector table
// and randomized strobes checked against a rule-level reference model.
module tb_selector_sync;

    localparam int TO_MAIN = 200;
    localparam int NW      = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cmd_in = '0;
    logic       cmd_strobe = 1'b0;
    logic       wrap_pulse = 1'b0;
    logic [3:0] selector;
    logic       pending, changed, err;
    logic [7:0] err_cnt;

    logic [3:0] cmd_to = '0;
    logic       strobe_to = 1'b0;
    logic       wrap_to = 1'b0;
    logic [3:0] sel_to;
    logic       pend_to, chg_to, err_to;
    logic [7:0] ecnt_to;

    selector_sync #(.SYNC_STAGES(2), .NUM_WAVES(NW), .RESET_SEL(0), .WAIT_WRAP(1), .TIMEOUT(TO_MAIN)) dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_strobe(cmd_strobe), .wrap_pulse(wrap_pulse),
        .selector(selector), .pending(pending), .changed(changed), .err(err), .err_cnt(err_cnt)
    );

    selector_sync #(.SYNC_STAGES(2), .NUM_WAVES(NW), .RESET_SEL(0), .WAIT_WRAP(1), .TIMEOUT(20)) dut_to (
        .clk(clk), .rst(rst), .cmd_in(cmd_to), .cmd_strobe(strobe_to), .wrap_pulse(wrap_to),
        .selector(sel_to), .pending(pend_to), .changed(chg_to), .err(err_to), .err_cnt(ecnt_to)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Reference model: strobe history queue, deadline in absolute edge numbers
    bit         hq[$];
    int         e_cnt = 0;
    int         deadline = 0;
    logic [3:0] m_sel = '0;
    logic [3:0] m_pend_sel = '0;
    bit         m_pend = 0, m_chg = 0, m_err = 0;
    int         m_ecnt = 0;

    task model_reset();
        hq.delete();
        m_sel = '0; m_pend_sel = '0;
        m_pend = 0; m_chg = 0; m_err = 0; m_ecnt = 0;
    endtask

    task model_step();
        bit cap, bad, valid;
        e_cnt++;
        hq.push_front(cmd_strobe);
        if (hq.size() > 6) void'(hq.pop_back());
        cap   = (hq.size() >= 4) && hq[3] && !((hq.size() >= 5) && hq[4]);
        bad   = cap && (int'(cmd_in) >= NW);
        valid = cap && (int'(cmd_in) < NW) && !((cmd_in == m_sel) && !m_pend);
        m_chg = 0;
        m_err = 0;
        if (bad) begin
            m_err = 1;
            if (m_ecnt < 255) m_ecnt++;
        end
        if (valid && wrap_pulse) begin
            m_sel = cmd_in; m_pend = 0; m_chg = 1;
        end else if (valid) begin
            m_pend = 1; m_pend_sel = cmd_in; deadline = e_cnt + TO_MAIN;
        end else if (m_pend && (wrap_pulse || e_cnt == deadline)) begin
            m_sel = m_pend_sel; m_pend = 0; m_chg = 1;
        end
    endtask

    int err_pulses = 0, chg_pulses = 0, chg_to_cnt = 0;
    bit pend_seen = 0;

    always @(negedge clk) begin
        if (!rst) model_reset();
        else model_step();
        check("model_sel", int'(selector), int'(m_sel));
        check("model_pend", int'(pending), int'(m_pend));
        check("model_chg", int'(changed), int'(m_chg));
        check("model_err", int'(err), int'(m_err));
        check("model_ecnt", int'(err_cnt), m_ecnt);
        err_pulses += int'(err);
        chg_pulses += int'(changed);
        chg_to_cnt += int'(chg_to);
        if (pending) pend_seen = 1;
    end

    task automatic pulse_wrap();
        wrap_pulse = 1'b1;
        tick();
        wrap_pulse = 1'b0;
    endtask

    // Returns just after the edge on which the command is captured
    task automatic strobe_cmd(input logic [3:0] cmd, input bit wrap_at_cap);
        cmd_in = cmd;
        cmd_strobe = 1'b1;
        tick(2);
        cmd_strobe = 1'b0;
        tick();
        wrap_pulse = wrap_at_cap;
        tick();
        wrap_pulse = 1'b0;
    endtask

    typedef struct {
        logic [3:0] cmd;
        bit         wrap_at_cap;
        int         wrap_delay;
        bit         exp_err;
        logic [3:0] exp_sel;
        bit         exp_pend;
        bit         exp_chg;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, e0, hi, lo;

        vecs[0] = '{4'd1,  1'b0, 5, 1'b0, 4'd1, 1'b0, 1'b1};
        vecs[1] = '{4'd1,  1'b0, 0, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[2] = '{4'd9,  1'b0, 0, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[3] = '{4'd0,  1'b0, 0, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[4] = '{4'd5,  1'b1, 0, 1'b1, 4'd0, 1'b0, 1'b1};
        vecs[5] = '{4'd3,  1'b1, 0, 1'b0, 4'd3, 1'b0, 1'b1};
        vecs[6] = '{4'd2,  1'b0, 0, 1'b0, 4'd3, 1'b1, 1'b0};
        vecs[7] = '{4'd3,  1'b0, 3, 1'b0, 4'd3, 1'b0, 1'b1};
        vecs[8] = '{4'd3,  1'b1, 0, 1'b0, 4'd3, 1'b0, 1'b0};
        vecs[9] = '{4'd15, 1'b0, 0, 1'b1, 4'd3, 1'b0, 1'b0};

        // Reset held with strobe toggling
        for (int i = 0; i < 10; i++) begin
            cmd_strobe = (i % 2 == 1);
            cmd_in = 4'(i);
            tick();
            check("rst_sel", int'(selector), 0);
            check("rst_pend", int'(pending), 0);
            check("rst_ecnt", int'(err_cnt), 0);
        end
        cmd_strobe = 1'b0;
        tick();

        // Release, strobe cmd 2: pending on the 4th edge
        rst = 1'b1;
        cmd_in = 4'd2;
        cmd_strobe = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) cmd_strobe = 1'b0;
            check($sformatf("rel_pend_edge%0d", k), int'(pending), (k == 4) ? 1 : 0);
        end
        check("rel_sel", int'(selector), 0);
        pulse_wrap();
        check("rel_commit_sel", int'(selector), 2);

        // Wrap commit 100 cycles after pending
        strobe_cmd(4'd3, 1'b0);
        check("wrap_pend", int'(pending), 1);
        tick(99);
        check("wrap_sel_before", int'(selector), 2);
        pulse_wrap();
        check("wrap_sel", int'(selector), 3);
        check("wrap_chg", int'(changed), 1);
        check("wrap_pend_clr", int'(pending), 0);
        tick();
        check("wrap_chg_one", int'(changed), 0);

        // 300 invalid commands
        e0 = err_pulses;
        pend_seen = 0;
        repeat (300) strobe_cmd(4'd7, 1'b0);
        tick(2);
        check("inv_err_pulses", err_pulses - e0, 300);
        check("inv_ecnt_sat", int'(err_cnt), 255);
        check("inv_sel", int'(selector), 3);
        check("inv_pend_never", int'(pend_seen), 0);

        // Overwrite then wrap; then capture coincident with wrap
        strobe_cmd(4'd1, 1'b0);
        check("ovw_pend1", int'(pending), 1);
        strobe_cmd(4'd2, 1'b0);
        check("ovw_pend2", int'(pending), 1);
        tick(5);
        pulse_wrap();
        check("ovw_sel", int'(selector), 2);
        strobe_cmd(4'd3, 1'b1);
        check("sim_sel", int'(selector), 3);
        check("sim_pend", int'(pending), 0);
        check("sim_chg", int'(changed), 1);

        // Reset while pending discards the command
        strobe_cmd(4'd2, 1'b0);
        check("rmp_pend", int'(pending), 1);
        c0 = chg_pulses;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick(3);
        pulse_wrap();
        tick(2);
        check("rmp_sel", int'(selector), 0);
        check("rmp_no_chg", chg_pulses - c0, 0);
        check("rmp_pend", int'(pending), 0);

        // Timeout instance (TIMEOUT=20)
        check("to_sel_init", int'(sel_to), 0);
        cmd_to = 4'd1;
        strobe_to = 1'b1;
        tick(2);
        strobe_to = 1'b0;
        n = 0;
        while (!pend_to && n < 10) begin
            tick();
            n++;
        end
        check("to_pend_rise", int'(pend_to), 1);
        c0 = chg_to_cnt;
        n = 0;
        while (sel_to != 4'd1 && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", n, 20);
        check("to_pend_fall", int'(pend_to), 0);
        tick(3);
        check("to_chg_count", chg_to_cnt - c0, 1);
        check("to_err", int'(err_to), 0);
        check("to_ecnt", int'(ecnt_to), 0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            strobe_cmd(vecs[i].cmd, vecs[i].wrap_at_cap);
            check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].exp_err));
            if (vecs[i].wrap_delay > 0) begin
                tick(vecs[i].wrap_delay - 1);
                pulse_wrap();
            end
            check($sformatf("vec%0d_sel", i), int'(selector), int'(vecs[i].exp_sel));
            check($sformatf("vec%0d_pend", i), int'(pending), int'(vecs[i].exp_pend));
            check($sformatf("vec%0d_chg", i), int'(changed), int'(vecs[i].exp_chg));
        end
        tick(5);

        // Randomized strobes, gaps and wrap pulses
        for (int t = 0; t < 150; t++) begin
            cmd_in = 4'($urandom_range(0, 6));
            cmd_strobe = 1'b1;
            hi = $urandom_range(2, 4);
            lo = ($urandom_range(0, 7) == 0) ? $urandom_range(150, 260) : $urandom_range(2, 30);
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) cmd_strobe = 1'b0;
                wrap_pulse = ($urandom_range(0, 24) == 0);
                tick();
            end
            wrap_pulse = 1'b0;
            if (t == 75) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
        end
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
